// File: rtl/alu_cmd_acc.sv
// alu_cmd_acc: command FIFO, sequencer and accumulator around an external combinational ALU
module alu_cmd_acc #(
    parameter int DEPTH = 4
) (
    input  logic       Clock,
    input  logic       Reset_b,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_func,
    input  logic [3:0] cmd_a,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_func,
    input  logic [7:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [7:0] op_count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nxt;
    logic [6:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [7:0] acc;
    logic [3:0] op_a;
    logic [2:0] op_func;
    logic empty, full, push, pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign cmd_ready = !full;
    assign push = cmd_valid && !full;
    assign alu_a = op_a;
    assign alu_b = acc[3:0];
    assign alu_func = op_func;
    assign res_valid = state == RESP;
    assign res_data = acc;
    always_comb begin
        state_nxt = state;
        pop = 1'b0;
        case (state)
            IDLE: begin
                pop = !empty;
                state_nxt = empty ? IDLE : EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                pop = res_ready && !empty;
                state_nxt = !res_ready ? RESP : empty ? IDLE : EXEC;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge Clock)
        if (push) mem[wr_ptr] <= {cmd_func, cmd_a};
    always_ff @(posedge Clock or negedge Reset_b)
        if (!Reset_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    // LOAD and CLEAR bypass the ALU result entirely
    always_ff @(posedge Clock or negedge Reset_b)
        if (!Reset_b) begin
            state <= IDLE;
            acc <= 8'h00;
            op_a <= 4'h0;
            op_func <= 3'b000;
            op_count <= 8'h00;
        end else begin
            state <= state_nxt;
            if (pop) {op_func, op_a} <= mem[rd_ptr];
            if (state == EXEC)
                acc <= op_func == 3'b110 ? {4'h0, op_a} : op_func == 3'b111 ? 8'h00 : alu_out;
            if (state == RESP && res_ready) op_count <= op_count + 8'd1;
        end
endmodule
